// File: rtl/i2c_target_regs_if.sv
// rtl/i2c_target_regs_if.sv - I2C pad and Avalon-MM signal bundle for i2c_target_regs
interface i2c_target_regs_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output scl_in, sda_in, address, chipselect, write_n, writedata,
        input  sda_oe, readdata
    );

    modport slave (
        input  scl_in, sda_in, address, chipselect, write_n, writedata,
        output sda_oe, readdata
    );
endinterface

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with 8-byte register file shared with an Avalon-MM port
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR = 7'h40
) (
    input  logic        clk,
    input  logic        reset,
    i2c_target_regs_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
    } state_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // [0],[1] are the synchronizer; [1..3] are three samples for the majority vote
    logic [3:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_filt, sda_filt;
    logic       scl_rise, scl_fall, start_det, stop_det;

    assign scl_filt  = maj3(scl_sync_q[3:1]);
    assign sda_filt  = maj3(sda_sync_q[3:1]);
    assign scl_rise  =  scl_filt & ~scl_prev_q;
    assign scl_fall  = ~scl_filt &  scl_prev_q;
    assign start_det =  scl_filt &  scl_prev_q &  sda_prev_q & ~sda_filt;
    assign stop_det  =  scl_filt &  scl_prev_q & ~sda_prev_q &  sda_filt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[2:0], bus.sda_in};
            scl_prev_q <= scl_filt;
            sda_prev_q <= sda_filt;
        end
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d, sh_next;
    logic        sda_oe_q, sda_oe_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        wrote_q, wrote_d;
    logic        wr_done_q, wr_done_d;
    logic        i2c_we;
    logic [7:0]  regs_q [8];
    logic [31:0] readdata_q, rd_mux;
    logic        av_we, wr_clr;
    logic        unused_wdata;

    assign sh_next      = {sh_q[6:0], sda_filt};
    assign av_we        = bus.chipselect & ~bus.write_n;
    assign wr_clr       = av_we && (bus.address == 4'd8) && bus.writedata[1];
    assign unused_wdata = ^bus.writedata[31:8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        sda_oe_d  = sda_oe_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        wrote_d   = wrote_q;
        wr_done_d = wr_done_q & ~wr_clr;
        i2c_we    = 1'b0;
        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            wrote_d  = 1'b0;
            if (wrote_q) wr_done_d = 1'b1;
        end else if (start_det) begin
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (sh_next[7:1] == I2C_ADDR) begin
                            state_d = S_ADDR_ACK;
                            rw_d    = sh_next[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // First fall after the byte pulls SDA low, the next one releases it
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            state_d  = S_RD;
                            sh_d     = {regs_q[ptr_q][6:0], 1'b0};
                            sda_oe_d = ~regs_q[ptr_q][7];
                            cnt_d    = 4'd1;
                        end else if (state_q == S_ADDR_ACK) begin
                            state_d = S_PTR;
                        end else begin
                            state_d = S_WR;
                        end
                    end
                end
                S_PTR: if (scl_rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        ptr_d   = sh_next[2:0];
                        state_d = S_PTR_ACK;
                    end
                end
                S_WR: if (scl_rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        i2c_we  = 1'b1;
                        ptr_d   = ptr_q + 3'd1;
                        wrote_d = 1'b1;
                        state_d = S_WR_ACK;
                    end
                end
                S_RD: if (scl_fall) begin
                    if (cnt_q != 4'd8) begin
                        sda_oe_d = ~sh_q[7];
                        sh_d     = {sh_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 4'd1;
                    end else begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = S_RD_ACK;
                    end
                end
                // cnt_q == 1 marks an ACK seen, so the next fall reloads the shifter
                S_RD_ACK: begin
                    if (scl_rise && cnt_q == 4'd0) begin
                        ptr_d = ptr_q + 3'd1;
                        if (sda_filt) state_d = S_WAIT_STOP;
                        else          cnt_d   = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        state_d  = S_RD;
                        sh_d     = {regs_q[ptr_q][6:0], 1'b0};
                        sda_oe_d = ~regs_q[ptr_q][7];
                        cnt_d    = 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            sh_q      <= 8'd0;
            sda_oe_q  <= 1'b0;
            ptr_q     <= 3'd0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            wrote_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            sda_oe_q  <= sda_oe_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            wrote_q   <= wrote_d;
            wr_done_q <= wr_done_d;
        end
    end

    // The I2C write is issued last so it overrides an Avalon write to the same byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
        end else begin
            if (av_we && !bus.address[3]) regs_q[bus.address[2:0]] <= bus.writedata[7:0];
            if (i2c_we) regs_q[ptr_q] <= sh_next;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        if (!bus.address[3])
            rd_mux = {24'd0, regs_q[bus.address[2:0]]};
        else if (bus.address == 4'd8)
            rd_mux = {25'd0, ptr_q, 2'b00, wr_done_q, busy_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata_q <= 32'd0;
        else       readdata_q <= rd_mux;
    end

    assign bus.readdata = readdata_q;
    assign bus.sda_oe   = sda_oe_q;
endmodule
